// File: rtl/nonce_report_tx_if.sv
// Handshake bundle between the hasher control unit, nonce_report_tx and mipi_tx.
// The slave modport is the transmitter's view; master is the surrounding logic.
interface nonce_report_tx_if;
   logic        nonce_valid;
   logic [31:0] nonce_in;
   logic        tx_busy;
   logic        send_data;
   logic [31:0] tx_data;
   logic        fifo_full;
   logic [7:0]  drop_count;
   logic [15:0] frames_sent;

   modport slave (
      input  nonce_valid, nonce_in, tx_busy,
      output send_data, tx_data, fifo_full, drop_count, frames_sent
   );

   modport master (
      output nonce_valid, nonce_in, tx_busy,
      input  send_data, tx_data, fifo_full, drop_count, frames_sent
   );
endinterface

// File: rtl/nonce_report_tx.sv
// Queues golden nonces and frames each as NONC / nonce / {seq,csum} words for mipi_tx,
// emitting a "yako" keepalive word after a programmable idle period.
module nonce_report_tx #(
   parameter int unsigned FIFO_AW          = 2,
   parameter int unsigned KEEPALIVE_CYCLES = 16777216,
   parameter int unsigned ACCEPT_TIMEOUT   = 16
) (
   input  logic             hash_clk,
   input  logic             reset,
   nonce_report_tx_if.slave bus
);

   localparam int unsigned       DEPTH   = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]  DEPTH_C = DEPTH[FIFO_AW:0];
   localparam logic [31:0]       W_NONC  = 32'h4E4F4E43;
   localparam logic [31:0]       W_KA    = 32'h79616B6F;
   localparam logic [31:0]       KA_LAST = KEEPALIVE_CYCLES - 1;
   localparam logic [31:0]       ACC_LAST = (ACCEPT_TIMEOUT == 0) ? 32'd0 : ACCEPT_TIMEOUT - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_ACC,
      S_WAIT_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        mem_q [0:DEPTH-1];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               full_q, full_d;
   logic [7:0]         drop_q, drop_d;
   logic [15:0]        frames_q, frames_d;
   logic [15:0]        seq_q, seq_d;
   logic [31:0]        nonce_q, nonce_d;
   logic [1:0]         idx_q, idx_d;
   logic               ka_q, ka_d;
   logic [31:0]        ka_cnt_q, ka_cnt_d;
   logic [31:0]        acc_cnt_q, acc_cnt_d;
   logic               send_q, send_d;
   logic [31:0]        txd_q, txd_d;
   logic               push, pop;
   logic [15:0]        csum;

   always_comb begin
      state_d   = state_q;
      nonce_d   = nonce_q;
      idx_d     = idx_q;
      ka_d      = ka_q;
      ka_cnt_d  = '0;
      acc_cnt_d = acc_cnt_q;
      seq_d     = seq_q;
      frames_d  = frames_q;
      send_d    = 1'b0;
      txd_d     = txd_q;
      pop       = 1'b0;
      csum      = nonce_q[31:16] + nonce_q[15:0] + seq_q;

      case (state_q)
         S_IDLE: begin
            // A pending nonce takes priority over a keepalive due in the same cycle.
            if (count_q != '0) begin
               pop     = 1'b1;
               nonce_d = mem_q[rd_ptr_q];
               idx_d   = 2'd0;
               ka_d    = 1'b0;
               state_d = S_SEND;
            end else if (KEEPALIVE_CYCLES != 0 && ka_cnt_q == KA_LAST) begin
               ka_d    = 1'b1;
               state_d = S_SEND;
            end else begin
               ka_cnt_d = ka_cnt_q + 32'd1;
            end
         end
         S_SEND: begin
            if (!bus.tx_busy) begin
               send_d    = 1'b1;
               acc_cnt_d = '0;
               state_d   = S_WAIT_ACC;
               if (ka_q)              txd_d = W_KA;
               else if (idx_q == 2'd0) txd_d = W_NONC;
               else if (idx_q == 2'd1) txd_d = nonce_q;
               else                    txd_d = {seq_q, csum};
            end
         end
         S_WAIT_ACC: begin
            if (bus.tx_busy || acc_cnt_q == ACC_LAST) state_d = S_WAIT_DONE;
            else                                     acc_cnt_d = acc_cnt_q + 32'd1;
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               if (ka_q) begin
                  ka_d    = 1'b0;
                  state_d = S_IDLE;
               end else if (idx_q != 2'd2) begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_SEND;
               end else begin
                  seq_d    = seq_q + 16'd1;
                  frames_d = frames_q + 16'd1;
                  state_d  = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A push into a full FIFO is still accepted when the FSM pops in the same cycle.
      push     = bus.nonce_valid && (count_q != DEPTH_C || pop);
      wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
         2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == DEPTH_C);
      drop_d = drop_q;
      if (bus.nonce_valid && !push && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         drop_q    <= '0;
         frames_q  <= '0;
         seq_q     <= '0;
         nonce_q   <= '0;
         idx_q     <= '0;
         ka_q      <= 1'b0;
         ka_cnt_q  <= '0;
         acc_cnt_q <= '0;
         send_q    <= 1'b0;
         txd_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         drop_q    <= drop_d;
         frames_q  <= frames_d;
         seq_q     <= seq_d;
         nonce_q   <= nonce_d;
         idx_q     <= idx_d;
         ka_q      <= ka_d;
         ka_cnt_q  <= ka_cnt_d;
         acc_cnt_q <= acc_cnt_d;
         send_q    <= send_d;
         txd_q     <= txd_d;
      end
   end

   always_ff @(posedge hash_clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.nonce_in;
   end

   assign bus.send_data   = send_q;
   assign bus.tx_data     = txd_q;
   assign bus.fifo_full   = full_q;
   assign bus.drop_count  = drop_q;
   assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_nonce_report_tx.sv
// Directed bench for nonce_report_tx: framing, FIFO overflow, keepalive, accept timeout,
// mid-frame reset and drop counter saturation.
module tb_nonce_report_tx;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   nonce_report_tx_if ifa ();
   nonce_report_tx_if ifb ();

   nonce_report_tx #(.FIFO_AW(2), .KEEPALIVE_CYCLES(16777216), .ACCEPT_TIMEOUT(16)) dut_a (
      .hash_clk (clk),
      .reset    (reset),
      .bus      (ifa.slave)
   );

   nonce_report_tx #(.FIFO_AW(2), .KEEPALIVE_CYCLES(8), .ACCEPT_TIMEOUT(16)) dut_b (
      .hash_clk (clk),
      .reset    (reset),
      .bus      (ifb.slave)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          mode_a   = 0;   // 0: busy 3 cycles per strobe, 1: stuck high, 2: never rises
   int          cnt_a    = 0;
   int          cnt_b    = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   int          ta[$];
   int          tb_t[$];

   logic [31:0] exp_n[5]  = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
   logic [31:0] exp_w2[5] = '{32'h0000_1112, 32'h0001_2225, 32'h0002_3338, 32'h0003_444B, 32'h0004_555E};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Strobe monitor, sampled just after the active edge.
   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ifa.send_data === 1'b1) begin qa.push_back(ifa.tx_data); ta.push_back(cyc); end
      if (ifb.send_data === 1'b1) begin qb.push_back(ifb.tx_data); tb_t.push_back(cyc); end
   end

   // mipi_tx stand-ins.
   initial begin
      ifa.tx_busy = 1'b0;
      ifb.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         case (mode_a)
            0: begin
               if (ifa.send_data === 1'b1) cnt_a = 3;
               else if (cnt_a > 0) cnt_a--;
               ifa.tx_busy = (cnt_a > 0);
            end
            1: begin cnt_a = 0; ifa.tx_busy = 1'b1; end
            default: begin cnt_a = 0; ifa.tx_busy = 1'b0; end
         endcase
         if (ifb.send_data === 1'b1) cnt_b = 3;
         else if (cnt_b > 0) cnt_b--;
         ifb.tx_busy = (cnt_b > 0);
      end
   end

   task automatic push_nonce(input logic [31:0] n);
      ifa.nonce_valid = 1'b1;
      ifa.nonce_in    = n;
      @(negedge clk);
      ifa.nonce_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      qa.delete();
      ta.delete();
   endtask

   task automatic wait_frames(input string tag, input logic [15:0] n, input int budget);
      for (int i = 0; i < budget && ifa.frames_sent !== n; i++) @(negedge clk);
      chk(tag, 32'(ifa.frames_sent), 32'(n));
   endtask

   task automatic chk_frame(input string tag, input int base, input logic [31:0] n,
                            input logic [31:0] w2);
      chk({tag, "_w0"}, qa[base],     32'h4E4F4E43);
      chk({tag, "_w1"}, qa[base + 1], n);
      chk({tag, "_w2"}, qa[base + 2], w2);
   endtask

   initial begin
      reset           = 1'b1;
      ifa.nonce_valid = 1'b0;
      ifa.nonce_in    = '0;
      ifb.nonce_valid = 1'b0;
      ifb.nonce_in    = '0;
      repeat (3) @(negedge clk);
      chk("rst_send",   32'(ifa.send_data),   32'd0);
      chk("rst_txdata", ifa.tx_data,          32'd0);
      chk("rst_full",   32'(ifa.fifo_full),   32'd0);
      chk("rst_drop",   32'(ifa.drop_count),  32'd0);
      chk("rst_frames", 32'(ifa.frames_sent), 32'd0);
      reset = 1'b0;

      // Single frame and 3-cycle latency; csum = 1234 + 5678 + 0.
      push_nonce(32'h1234_5678);
      chk("lat_c1", 32'(ifa.send_data), 32'd0);
      @(negedge clk);
      chk("lat_c2", 32'(ifa.send_data), 32'd0);
      @(negedge clk);
      chk("lat_c3", 32'(ifa.send_data), 32'd1);
      wait_frames("t1_frames", 16'd1, 200);
      chk("t1_nwords", 32'(qa.size()), 32'd3);
      chk_frame("t1", 0, 32'h1234_5678, 32'h0000_68AC);

      // Keepalive instance: 8 idle + send + accept + 3 busy = 13-cycle period.
      for (int i = 0; i < 200 && qb.size() < 4; i++) @(negedge clk);
      chk("ka_nwords", 32'(qb.size() >= 4), 32'd1);
      chk("ka_first_t", 32'(tb_t[0]), 32'd12);
      for (int k = 0; k < 4; k++) chk("ka_word", qb[k], 32'h79616B6F);
      for (int k = 1; k < 4; k++) chk("ka_period", 32'(tb_t[k] - tb_t[k-1]), 32'd13);
      chk("ka_frames", 32'(ifb.frames_sent), 32'd0);

      // Overflow: first nonce is popped at once, four fill the FIFO, two are dropped.
      mode_a = 1;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         push_nonce((k < 5) ? exp_n[k] : 32'hBAD0_0000 + 32'(k));
         if (k == 3) chk("ovf_notfull4", 32'(ifa.fifo_full), 32'd0);
         if (k == 4) chk("ovf_full5",    32'(ifa.fifo_full), 32'd1);
      end
      chk("ovf_drop",   32'(ifa.drop_count), 32'd2);
      chk("ovf_nosend", 32'(qa.size()),      32'd0);
      mode_a = 0;
      wait_frames("ovf_frames", 16'd5, 600);
      chk("ovf_nwords", 32'(qa.size()), 32'd15);
      for (int f = 0; f < 5; f++) chk_frame("ovf", 3 * f, exp_n[f], exp_w2[f]);
      chk("ovf_empty", 32'(ifa.fifo_full), 32'd0);

      // Accept timeout: busy never rises, strobes 1 + 16 + 1 cycles apart.
      mode_a = 2;
      do_reset();
      push_nonce(32'hDEAD_BEEF);
      wait_frames("to_frames", 16'd1, 300);
      chk("to_nwords", 32'(qa.size()), 32'd3);
      chk_frame("to", 0, 32'hDEAD_BEEF, 32'h0000_9D9C);
      chk("to_gap1", 32'(ta[1] - ta[0]), 32'd18);
      chk("to_gap2", 32'(ta[2] - ta[1]), 32'd18);

      // Reset while waiting for W1 to complete.
      mode_a = 0;
      do_reset();
      push_nonce(32'h0000_0005);
      for (int i = 0; i < 100 && qa.size() < 2; i++) @(negedge clk);
      chk("mr_w1_seen", 32'(qa.size()), 32'd2);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mr_send",   32'(ifa.send_data),   32'd0);
      chk("mr_txdata", ifa.tx_data,          32'd0);
      chk("mr_full",   32'(ifa.fifo_full),   32'd0);
      chk("mr_drop",   32'(ifa.drop_count),  32'd0);
      chk("mr_frames", 32'(ifa.frames_sent), 32'd0);
      reset = 1'b0;
      qa.delete();
      push_nonce(32'h0000_0007);
      wait_frames("mr_frames2", 16'd1, 200);
      chk("mr_nwords", 32'(qa.size()), 32'd3);
      chk_frame("mr", 0, 32'h0000_0007, 32'h0000_0007);

      // Drop counter saturation.
      mode_a = 1;
      do_reset();
      for (int k = 0; k < 259; k++) push_nonce(32'(k));
      chk("sat_254", 32'(ifa.drop_count), 32'd254);
      for (int k = 259; k < 300; k++) push_nonce(32'(k));
      chk("sat_255", 32'(ifa.drop_count), 32'd255);
      chk("sat_full", 32'(ifa.fifo_full), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
